// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle MIPS datapath (one memory, one ALU).
// Ports: clk, reset_n (async active-low); opcode/funct from the IR, zero from the ALU,
//   mem_ready memory handshake; datapath enables (pc_en, IRWrite, MemWrite, RegWrite),
//   selects (IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALU_control),
//   illegal pulse and the debug state.
// Optional: define BNE_EN to decode opcode 000101 (bne) as an inverted-sense branch.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [2:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALU_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTEXEC = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB = STATE_W'(10);
  localparam logic [STATE_W-1:0] JUMP   = STATE_W'(11);

  logic [STATE_W-1:0] state_q, state_d;
  logic               st_q, st_d;
  logic               pc_en_c, irw_c, mw_c, rw_c, ill_c, taken_c;

  // lw/sw choice is latched in DECODE so MEMADR does not depend on the IR.
  assign st_d = (state_q == DECODE) ? (opcode == 6'b101011) : st_q;

`ifdef BNE_EN
  logic bne_q, bne_d;
  assign bne_d   = (state_q == DECODE) ? (opcode == 6'b000101) : bne_q;
  assign taken_c = zero ^ bne_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bne_q <= 1'b0;
    else bne_q <= bne_d;
`else
  assign taken_c = zero;
`endif

  always_comb begin
    state_d     = state_q;
    pc_en_c     = 1'b0;
    irw_c       = 1'b0;
    mw_c        = 1'b0;
    rw_c        = 1'b0;
    ill_c       = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 3'b000;
    PCSrc       = 2'b00;
    ALU_control = 3'b010;
    case (state_q)
      FETCH: begin
        ALUSrcB = 3'b001;
        irw_c   = mem_ready;
        pc_en_c = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 3'b011;
        if (opcode == 6'b100011 || opcode == 6'b101011) state_d = MEMADR;
        else if (opcode == 6'b000000) state_d = RTEXEC;
        else if (opcode == 6'b000100) state_d = BRANCH;
`ifdef BNE_EN
        else if (opcode == 6'b000101) state_d = BRANCH;
`endif
        else if (opcode == 6'b001000) state_d = ADDIEX;
        else if (opcode == 6'b000010) state_d = JUMP;
        else begin
          state_d = FETCH;
          ill_c   = 1'b1;
        end
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'b010;
        state_d = st_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        rw_c     = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        IorD    = 1'b1;
        mw_c    = 1'b1;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      RTEXEC: begin
        ALUSrcA = 1'b1;
        state_d = ALUWB;
        case (funct)
          6'b100000: ALU_control = 3'b010;
          6'b100010: ALU_control = 3'b110;
          6'b100100: ALU_control = 3'b000;
          6'b100101: ALU_control = 3'b001;
          6'b101010: ALU_control = 3'b111;
          6'b000000: begin
            ALU_control = 3'b011;
            ALUSrcB     = 3'b100;
          end
          default: begin
            ill_c   = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      ALUWB: begin
        RegDst  = 1'b1;
        rw_c    = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_control = 3'b110;
        PCSrc       = 2'b01;
        pc_en_c     = taken_c;
        state_d     = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'b010;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        rw_c    = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        pc_en_c = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= FETCH;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
    end

  // Reset holds state at FETCH, whose enables follow mem_ready; mask them so
  // nothing is written while reset_n is low.
  assign pc_en    = pc_en_c & reset_n;
  assign IRWrite  = irw_c & reset_n;
  assign MemWrite = mw_c & reset_n;
  assign RegWrite = rw_c & reset_n;
  assign illegal  = ill_c & reset_n;
  assign state    = state_q;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences a multicycle MIPS datapath sharing one memory and one ALU across instruction phases. Decodes `opcode`/`funct` and steps each instruction through fetch, decode, execute, memory and writeback states. Drives every enable and mux select of the datapath and stalls on a memory ready handshake.

## Interface
- `STATE_W`, 4: state register width.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: instruction register `[31:26]`.
- `funct` input 6: instruction register `[5:0]`.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_en` output 1: PC register load.
- `IorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` output 1: instruction register load.
- `MemWrite` output 1: memory write strobe.
- `RegWrite` output 1: register file write.
- `RegDst` output 1: write register select; 0 = rt, 1 = rd.
- `MemtoReg` output 1: writeback select; 0 = ALUOut, 1 = data register.
- `ALUSrcA` output 1: ALU A select; 0 = PC, 1 = RD1.
- `ALUSrcB` output 3: ALU B select; 000 = RD2, 001 = const 4, 010 = SignImm, 011 = SignImm<<2, 100 = shamt.
- `PCSrc` output 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALU_control` output 3: ALU operation; 000 AND, 001 OR, 010 ADD, 011 SLL, 110 SUB, 111 SLT.
- `illegal` output 1: one-cycle pulse on an unsupported opcode or funct.
- `state` output `STATE_W`: current state, for debug.

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), RTEXEC(6), ALUWB(7), BRANCH(8), ADDIEX(9), ADDIWB(10), JUMP(11).
- Unlisted outputs are 0 in every state. `ALU_control` defaults to 010.
- **FETCH:** `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=001, `PCSrc`=00.
  - `IRWrite` and `pc_en` are asserted only when `mem_ready`=1, which also moves the FSM to DECODE.
  - Otherwise the FSM stays in FETCH.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=011 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 → MEMADR.
  - 000000 → RTEXEC.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Any other opcode → FETCH with `illegal`=1.
- **MEMADR:** `ALUSrcA`=1, `ALUSrcB`=010. Next state is MEMRD for lw, MEMWR for sw.
- **MEMRD:** `IorD`=1. Holds until `mem_ready`, then → MEMWB.
- **MEMWB:** `RegDst`=0, `MemtoReg`=1, `RegWrite`=1. Next state FETCH.
- **MEMWR:** `IorD`=1, `MemWrite`=1.
  - `MemWrite` stays high until and including the `mem_ready` cycle.
  - Next state FETCH on `mem_ready`.
- **RTEXEC:** `ALUSrcA`=1, `ALUSrcB`=000. funct decode:
  - 100000 add → ADD.
  - 100010 sub → SUB.
  - 100100 and → AND.
  - 100101 or → OR.
  - 101010 slt → SLT.
  - 000000 sll → SLL, with `ALUSrcB`=100.
  - Any other funct → `illegal`=1 and next state FETCH; ALUWB is skipped, so no register write occurs.
- **ALUWB:** `RegDst`=1, `MemtoReg`=0, `RegWrite`=1. Next state FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=000, SUB, `PCSrc`=01, `pc_en`=`zero`. Next state FETCH.
- **ADDIEX:** `ALUSrcA`=1, `ALUSrcB`=010, ADD. Next state ADDIWB.
- **ADDIWB:** `RegDst`=0, `MemtoReg`=0, `RegWrite`=1. Next state FETCH.
- **JUMP:** `PCSrc`=10, `pc_en`=1. Next state FETCH.
- Unreachable state encodings (12-15) → FETCH with all enables 0.

## Timing
- `state` is registered. Outputs decode combinationally from `state`, plus `mem_ready` (FETCH, MEMRD, MEMWR), `zero` (BRANCH), and `opcode`/`funct`.
- Reset:
  - `reset_n` low immediately forces `state`=FETCH.
  - While `reset_n` is low, all enables (`pc_en`, `IRWrite`, `MemWrite`, `RegWrite`) and `illegal` are 0. Selects take their FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes.
- Cycles per instruction with `mem_ready` tied high:
  - lw 5; sw, R-type and addi 4; beq and j 3.
  - Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `opcode`/`funct` are sampled only in DECODE and RTEXEC. The IR must be stable after the FETCH load.

## Configuration
- `BNE_EN` defined:
  - Opcode 000101 decodes to BRANCH with `pc_en`=~`zero`.
  - A one-bit flag captured in DECODE selects the sense.
- `BNE_EN` undefined: 000101 is illegal (→ FETCH, `illegal`=1).

## Test plan
- Reset, then release with `mem_ready`=1 and lw (0x8C...): `state` sequence 0,1,2,3,4,0; `IRWrite` in cycle 1 only; `RegWrite`=1, `MemtoReg`=1 in state 4.
- sw with `mem_ready` low for 2 cycles in MEMWR: `MemWrite` high for 3 consecutive cycles, then `state`=FETCH.
- R-type add/sub/and/or/slt/sll: `ALU_control` 010/110/000/001/111/011 in RTEXEC; sll gives `ALUSrcB`=100; funct 0x3F gives `illegal` and no `RegWrite`.
- beq: `zero`=1 gives `pc_en`=1, `PCSrc`=01 in BRANCH; `zero`=0 gives `pc_en`=0.
- j: `PCSrc`=10, `pc_en`=1, 3 cycles total. Opcode 0x3F gives `illegal` pulse in DECODE, then FETCH.
- `reset_n` asserted in MEMWR with `MemWrite`=1: `MemWrite` drops to 0 immediately and `state`=0.
